// File: rtl/mem_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI-Lite arbiter.
// A registered grant is held for one full transaction; granted channels pass straight through.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] ifu_araddr_i,
  input  logic                  ifu_arvalid_i,
  output logic                  ifu_arready_o,
  output logic [DATA_WIDTH-1:0] ifu_rdata_o,
  output logic                  ifu_rvalid_o,
  input  logic                  ifu_rready_i,
  input  logic [ADDR_WIDTH-1:0] lsu_araddr_i,
  input  logic                  lsu_arvalid_i,
  output logic                  lsu_arready_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  lsu_rvalid_o,
  input  logic                  lsu_rready_i,
  input  logic [ADDR_WIDTH-1:0] lsu_awaddr_i,
  input  logic                  lsu_awvalid_i,
  output logic                  lsu_awready_o,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  input  logic [STRB_WIDTH-1:0] lsu_wstrb_i,
  input  logic                  lsu_wvalid_i,
  output logic                  lsu_wready_o,
  output logic [1:0]            lsu_bresp_o,
  output logic                  lsu_bvalid_o,
  input  logic                  lsu_bready_i,
  output logic [ADDR_WIDTH-1:0] mem_araddr_o,
  output logic                  mem_arvalid_o,
  input  logic                  mem_arready_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic [1:0]            mem_rresp_i,
  input  logic                  mem_rvalid_i,
  output logic                  mem_rready_o,
  output logic [ADDR_WIDTH-1:0] mem_awaddr_o,
  output logic                  mem_awvalid_o,
  input  logic                  mem_awready_i,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [STRB_WIDTH-1:0] mem_wstrb_o,
  output logic                  mem_wvalid_o,
  input  logic                  mem_wready_i,
  input  logic [1:0]            mem_bresp_i,
  input  logic                  mem_bvalid_i,
  output logic                  mem_bready_o
);

  typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_t;

  state_t state_q, state_d;
  logic   ar_done, aw_done, w_done;

  // Done flags mask repeated beats from masters that hold valid until the response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        ar_done <= 1'b0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (mem_arvalid_o && mem_arready_i) ar_done <= 1'b1;
        if (mem_awvalid_o && mem_awready_i) aw_done <= 1'b1;
        if (mem_wvalid_o && mem_wready_i)   w_done  <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (lsu_awvalid_i)      state_d = LSU_WR;
        else if (lsu_arvalid_i) state_d = LSU_RD;
        else if (ifu_arvalid_i) state_d = IFU_RD;
      end
      IFU_RD: if (mem_rvalid_i && ifu_rready_i) state_d = IDLE;
      LSU_RD: if (mem_rvalid_i && lsu_rready_i) state_d = IDLE;
      LSU_WR: if (mem_bvalid_i && lsu_bready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ifu_arready_o = 1'b0;
    ifu_rdata_o   = '0;
    ifu_rvalid_o  = 1'b0;
    lsu_arready_o = 1'b0;
    lsu_rdata_o   = '0;
    lsu_rvalid_o  = 1'b0;
    lsu_awready_o = 1'b0;
    lsu_wready_o  = 1'b0;
    lsu_bresp_o   = '0;
    lsu_bvalid_o  = 1'b0;
    mem_araddr_o  = '0;
    mem_arvalid_o = 1'b0;
    mem_rready_o  = 1'b0;
    mem_awaddr_o  = '0;
    mem_awvalid_o = 1'b0;
    mem_wdata_o   = '0;
    mem_wstrb_o   = '0;
    mem_wvalid_o  = 1'b0;
    mem_bready_o  = 1'b0;
    case (state_q)
      IFU_RD: begin
        mem_araddr_o  = ifu_araddr_i;
        mem_arvalid_o = ifu_arvalid_i && !ar_done;
        ifu_arready_o = mem_arready_i && !ar_done;
        ifu_rdata_o   = mem_rdata_i;
        ifu_rvalid_o  = mem_rvalid_i;
        mem_rready_o  = ifu_rready_i;
      end
      LSU_RD: begin
        mem_araddr_o  = lsu_araddr_i;
        mem_arvalid_o = lsu_arvalid_i && !ar_done;
        lsu_arready_o = mem_arready_i && !ar_done;
        lsu_rdata_o   = mem_rdata_i;
        lsu_rvalid_o  = mem_rvalid_i;
        mem_rready_o  = lsu_rready_i;
      end
      LSU_WR: begin
        mem_awaddr_o  = lsu_awaddr_i;
        mem_awvalid_o = lsu_awvalid_i && !aw_done;
        lsu_awready_o = mem_awready_i && !aw_done;
        mem_wdata_o   = lsu_wdata_i;
        mem_wstrb_o   = lsu_wstrb_i;
        mem_wvalid_o  = lsu_wvalid_i && !w_done;
        lsu_wready_o  = mem_wready_i && !w_done;
        lsu_bresp_o   = mem_bresp_i;
        lsu_bvalid_o  = mem_bvalid_i;
        mem_bready_o  = lsu_bready_i;
      end
      default: ;
    endcase
  end

  // Read error responses are not forwarded to the masters, so flag them here instead.
  rresp_okay: assert property (@(posedge clk_i) disable iff (rst_i)
    (mem_rvalid_i && mem_rready_o) |-> (mem_rresp_i == 2'b00));

endmodule
